// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen
// Shifts a parallel pattern out on `x`, MSB-first, one bit per enabled
// clock. The pattern is sent repeats+1 times, with `gap` idle cycles between
// frames, and a one-cycle `done` pulse marks the end of the transfer.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   allow    in   global enable; when low, all state and outputs freeze
//   start    in   transfer request, sampled only in IDLE
//   pattern  in   WIDTH bits; the low `len` bits are sent, pattern[len-1] first
//   len      in   frame length (0 = empty transfer, values above WIDTH clamp)
//   repeats  in   extra frames (total frames = repeats+1); named `repeats`
//                 because `repeat` is a reserved word
//   gap      in   idle cycles between frames, none after the last frame
//   x        out  serial data (registered)
//   x_valid  out  high while x carries a pattern bit (registered)
//   busy     out  high in SEND and GAP (registered)
//   done     out  one-cycle completion pulse (registered)
module serial_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int LENW  = 4,
  parameter int CNTW  = 4,
  parameter int GAPW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             allow,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LENW-1:0]  len,
  input  logic [CNTW-1:0]  repeats,
  input  logic [GAPW-1:0]  gap,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [LENW-1:0] LEN_ZERO = LENW'(0);
  localparam logic [LENW-1:0] LEN_ONE  = LENW'(1);
  localparam logic [LENW-1:0] LEN_MAX  = LENW'(WIDTH);
  localparam logic [CNTW-1:0] CNT_ZERO = CNTW'(0);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [GAPW-1:0] GAP_ZERO = GAPW'(0);
  localparam logic [GAPW-1:0] GAP_ONE  = GAPW'(1);

  // Limit a requested frame length to the pattern width.
  function automatic logic [LENW-1:0] clamp_len(input logic [LENW-1:0] l);
    if (l > LEN_MAX) begin
      return LEN_MAX;
    end else begin
      return l;
    end
  endfunction

  state_t            state_r, state_s;
  logic [WIDTH-1:0]  pat_r, pat_s;
  logic [LENW-1:0]   len_r, len_s;
  logic [CNTW-1:0]   rep_r, rep_s;
  logic [GAPW-1:0]   gap_r, gap_s;
  logic [LENW-1:0]   idx_r, idx_s;
  logic [CNTW-1:0]   frm_r, frm_s;
  logic [GAPW-1:0]   gcnt_r, gcnt_s;
  logic [LENW-1:0]   len_req_s;

  logic              x_s, x_valid_s, busy_s, done_s;
  logic [LENW-1:0]   bit_sel_s;
  logic [WIDTH-1:0]  pat_shift_s;

  // State, transfer registers and outputs; everything holds while allow is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      pat_r   <= {WIDTH{1'b0}};
      len_r   <= LEN_ZERO;
      rep_r   <= CNT_ZERO;
      gap_r   <= GAP_ZERO;
      idx_r   <= LEN_ZERO;
      frm_r   <= CNT_ZERO;
      gcnt_r  <= GAP_ZERO;
      x       <= 1'b0;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (allow) begin
      state_r <= state_s;
      pat_r   <= pat_s;
      len_r   <= len_s;
      rep_r   <= rep_s;
      gap_r   <= gap_s;
      idx_r   <= idx_s;
      frm_r   <= frm_s;
      gcnt_r  <= gcnt_s;
      x       <= x_s;
      x_valid <= x_valid_s;
      busy    <= busy_s;
      done    <= done_s;
    end else begin
      state_r <= state_r;
      pat_r   <= pat_r;
      len_r   <= len_r;
      rep_r   <= rep_r;
      gap_r   <= gap_r;
      idx_r   <= idx_r;
      frm_r   <= frm_r;
      gcnt_r  <= gcnt_r;
      x       <= x;
      x_valid <= x_valid;
      busy    <= busy;
      done    <= done;
    end
  end

  // Next-state and next-counter logic.
  always_comb begin
    state_s   = state_r;
    pat_s     = pat_r;
    len_s     = len_r;
    rep_s     = rep_r;
    gap_s     = gap_r;
    idx_s     = idx_r;
    frm_s     = frm_r;
    gcnt_s    = gcnt_r;
    len_req_s = clamp_len(len);

    case (state_r)
      IDLE: begin
        if (start) begin
          pat_s  = pattern;
          len_s  = len_req_s;
          rep_s  = repeats;
          gap_s  = gap;
          idx_s  = LEN_ZERO;
          frm_s  = CNT_ZERO;
          gcnt_s = GAP_ZERO;
          if (len_req_s != LEN_ZERO) begin
            state_s = SEND;
          end else begin
            state_s = FIN;
          end
        end else begin
          state_s = IDLE;
        end
      end

      SEND: begin
        if (idx_r == len_r - LEN_ONE) begin
          if (frm_r == rep_r) begin
            state_s = FIN;
          end else begin
            frm_s  = frm_r + CNT_ONE;
            idx_s  = LEN_ZERO;
            gcnt_s = GAP_ZERO;
            if (gap_r != GAP_ZERO) begin
              state_s = GAP;
            end else begin
              state_s = SEND;
            end
          end
        end else begin
          idx_s = idx_r + LEN_ONE;
        end
      end

      GAP: begin
        if (gcnt_r == gap_r - GAP_ONE) begin
          state_s = SEND;
          idx_s   = LEN_ZERO;
          gcnt_s  = GAP_ZERO;
        end else begin
          gcnt_s = gcnt_r + GAP_ONE;
        end
      end

      FIN: begin
        state_s = IDLE;
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output values for the cycle after the edge, derived from the next state so
  // that x/x_valid/busy/done can be registered without an extra cycle of lag.
  always_comb begin
    bit_sel_s   = len_s - LEN_ONE - idx_s;
    pat_shift_s = pat_s >> bit_sel_s;
    x_s         = 1'b0;
    x_valid_s   = 1'b0;
    busy_s      = 1'b0;
    done_s      = 1'b0;

    case (state_s)
      SEND: begin
        x_s       = pat_shift_s[0];
        x_valid_s = 1'b1;
        busy_s    = 1'b1;
      end
      GAP: begin
        busy_s = 1'b1;
      end
      FIN: begin
        done_s = 1'b1;
      end
      default: begin
        x_s = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_pattern_gen.sv
module tb_serial_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       allow;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [3:0] repeats;
  logic [3:0] gap;
  logic       x, x_valid, busy, done;

  int errs = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // expected {x, x_valid, busy, done} per enabled cycle
  logic [3:0] q[$];
  logic [3:0] cur = 4'b0000;

  serial_pattern_gen #(.WIDTH(8), .LENW(4), .CNTW(4), .GAPW(4)) dut (
    .clk(clk), .rst(rst), .allow(allow), .start(start),
    .pattern(pattern), .len(len), .repeats(repeats), .gap(gap),
    .x(x), .x_valid(x_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-transfer expectation from the frame/gap rules.
  task automatic build(input logic [7:0] p, input int l, input int r, input int g);
    int lc;
    lc = (l > 8) ? 8 : l;
    if (lc != 0) begin
      for (int f = 0; f <= r; f++) begin
        for (int b = lc - 1; b >= 0; b--) q.push_back({p[b], 1'b1, 1'b1, 1'b0});
        if (f < r) begin
          for (int k = 0; k < g; k++) q.push_back(4'b0010);
        end
      end
    end
    q.push_back(4'b0001);
  endtask

  // Model step and per-cycle comparison.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      cur = 4'b0000;
    end else if (allow) begin
      if (q.size() > 0) begin
        cur = q.pop_front();
      end else if (!cur[0] && start) begin
        build(pattern, int'(len), int'(repeats), int'(gap));
        cur = q.pop_front();
      end else begin
        cur = 4'b0000;
      end
    end
    #2;
    if (chk_en && !rst) chk("cycle", {28'd0, x, x_valid, busy, done}, {28'd0, cur});
  end

  // Pulse start for one edge; returns at the negedge after the capture edge.
  task automatic start_xfer(input logic [7:0] p, input logic [3:0] l,
                            input logic [3:0] r, input logic [3:0] g);
    @(negedge clk);
    pattern = p; len = l; repeats = r; gap = g; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  logic [14:0] x_seq, xv_seq;
  int cyc, busy_cnt, done_cnt;

  initial begin
    rst = 1'b1; allow = 1'b1; start = 1'b0;
    pattern = 8'h00; len = 4'd0; repeats = 4'd0; gap = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {28'd0, x, x_valid, busy, done}, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_outs", {28'd0, x, x_valid, busy, done}, 32'd0);

    // single frame 0xB, len 4
    start_xfer(8'h0B, 4'd4, 4'd0, 4'd0);
    x_seq = 15'd0;
    for (int i = 0; i < 4; i++) begin
      chk("single_xv", {31'd0, x_valid}, 32'd1);
      x_seq = {x_seq[13:0], x};
      @(negedge clk);
    end
    chk("single_bits", {28'd0, x_seq[3:0]}, 32'hB);
    chk("single_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("single_done_end", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);

    // three frames of 101 with 3-cycle gaps
    start_xfer(8'h05, 4'd3, 4'd2, 4'd3);
    x_seq = 15'd0; xv_seq = 15'd0; busy_cnt = 0; cyc = 1;
    while (!done && cyc < 40) begin
      busy_cnt += int'(busy);
      x_seq  = {x_seq[13:0], x};
      xv_seq = {xv_seq[13:0], x_valid};
      @(negedge clk);
      cyc++;
    end
    chk("rep_done_seen", {31'd0, done}, 32'd1);
    chk("rep_done_cycle", cyc, 32'd16);
    chk("rep_busy_cycles", busy_cnt, 32'd15);
    chk("rep_x_seq", {17'd0, x_seq}, {17'd0, 15'b101000101000101});
    chk("rep_xv_seq", {17'd0, xv_seq}, {17'd0, 15'b111000111000111});
    repeat (2) @(negedge clk);

    // freeze for 3 cycles after the second bit
    start_xfer(8'h0B, 4'd4, 4'd0, 4'd0);
    x_seq = 15'd0;
    for (int i = 0; i < 7; i++) begin
      x_seq = {x_seq[13:0], x};
      if (i == 1) allow = 1'b0;
      if (i == 4) allow = 1'b1;
      if (i < 7) chk("freeze_nodone", {31'd0, done}, 32'd0);
      @(negedge clk);
    end
    chk("freeze_x_seq", {25'd0, x_seq[6:0]}, {25'd0, 7'b1000011});
    chk("freeze_done", {31'd0, done}, 32'd1);
    repeat (2) @(negedge clk);

    // empty transfer, with a freeze while done is high
    start_xfer(8'hFF, 4'd0, 4'd3, 4'd2);
    chk("empty_done", {31'd0, done}, 32'd1);
    chk("empty_busy", {30'd0, busy, x_valid}, 32'd0);
    allow = 1'b0;
    @(negedge clk);
    chk("empty_done_frozen", {31'd0, done}, 32'd1);
    allow = 1'b1;
    @(negedge clk);
    chk("empty_done_end", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);

    // len 15 clamps to 8 bits
    start_xfer(8'hA5, 4'd15, 4'd0, 4'd0);
    x_seq = 15'd0;
    for (int i = 0; i < 8; i++) begin
      chk("clamp_xv", {31'd0, x_valid}, 32'd1);
      x_seq = {x_seq[13:0], x};
      @(negedge clk);
    end
    chk("clamp_bits", {24'd0, x_seq[7:0]}, 32'hA5);
    chk("clamp_done", {31'd0, done}, 32'd1);
    repeat (2) @(negedge clk);

    // start during SEND and during FIN is ignored
    start_xfer(8'h0B, 4'd4, 4'd0, 4'd0);
    x_seq = 15'd0; done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 4) x_seq = {x_seq[13:0], x};
      done_cnt += int'(done);
      if (i == 1) begin start = 1'b1; pattern = 8'hFF; len = 4'd8; end
      if (i == 2) start = 1'b0;
      if (i == 4) start = 1'b1;
      if (i == 5) start = 1'b0;
      if (i >= 6) chk("ign_idle_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
    end
    chk("ign_bits", {28'd0, x_seq[3:0]}, 32'hB);
    chk("ign_done_count", done_cnt, 32'd1);

    // async reset on the third bit of an 8-bit frame
    start_xfer(8'hFF, 4'd8, 4'd0, 4'd0);
    repeat (2) @(negedge clk);
    chk("rst_third_bit", {30'd0, x, x_valid}, 32'd3);
    #1 rst = 1'b1;
    #1 chk("rst_async_outs", {28'd0, x, x_valid, busy, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      done_cnt += int'(done) + int'(busy);
      @(negedge clk);
    end
    chk("rst_no_done", done_cnt, 32'd0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
